// File: rtl/rsa2048_ahb_pkg.sv
// Shared constants and types for the RSA2048 AHB-Lite register front end.
// Register offsets, AHB encodings and the sequencing FSM state type.
package rsa2048_ahb_pkg;

  localparam int NWORDS = 64;
  localparam int XW     = 32 * NWORDS;

  localparam logic [31:0] CTRL_OFS = 32'h0000_0000;
  localparam logic [31:0] STAT_OFS = 32'h0000_0004;
  localparam logic [31:0] INFO_OFS = 32'h0000_0008;
  localparam logic [31:0] DATA_OFS = 32'h0000_0010;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY = 2'b00;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } rsa_state_e;

  // Only address bits [4:2] select a register.
  function automatic logic [2:0] reg_idx(input logic [31:0] ofs);
    return ofs[4:2];
  endfunction

  function automatic logic trans_valid(input logic [1:0] t);
    case (t)
      HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rsa2048_ahb_regs_if.sv
// AHB-Lite bus bundle between the fabric (master side) and the RSA register slave.
// Handshake: a transfer is accepted when HSEL & HREADY & HTRANS is NONSEQ/SEQ; the slave is always ready.
interface rsa2048_ahb_regs_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/rsa2048_word_buf.sv
// 2048-bit word buffer: shift-in from the top word down or parallel load,
// plus a wrapping word pointer and the word selected by it.
module rsa2048_word_buf
  import rsa2048_ahb_pkg::*;
#(
  parameter int NW = NWORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift_en,
  input  logic [31:0]             shift_word,
  input  logic                    load_en,
  input  logic [32*NW-1:0]        load_data,
  input  logic                    ptr_clr,
  input  logic                    ptr_inc,
  output logic [32*NW-1:0]        data,
  output logic [$clog2(NW)-1:0]   ptr,
  output logic [31:0]             rd_word
);
  localparam int PW = $clog2(NW);

  // New words enter at the top, so after NW shifts the first word is in bits [31:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load_en) begin
      data <= load_data;
    end else if (shift_en) begin
      data <= {shift_word, data[32*NW-1:32]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (ptr_clr) begin
      ptr <= '0;
    end else if (ptr_inc) begin
      ptr <= (ptr == PW'(NW - 1)) ? '0 : ptr + 1'b1;
    end
  end

  assign rd_word = data[{ptr, 5'b00000} +: 32];

endmodule

// File: rtl/rsa2048_ahb_regs.sv
// AHB-Lite register front end for the RSA2048 core: loads the 64-word operand,
// starts the core after the last word and serves the latched result word by word.
module rsa2048_ahb_regs
  import rsa2048_ahb_pkg::*;
(
  input  logic              HCLK,
  input  logic              HRESET,
  rsa2048_ahb_regs_if.slave bus,
  output logic              IRQ,
  output logic [XW-1:0]     rsa_x,
  output logic              rsa_start,
  input  logic              rsa_done,
  input  logic [XW-1:0]     rsa_y,
  output rsa_state_e        dbg_state
);
  localparam int         PW       = $clog2(NWORDS);
  localparam logic [2:0] CTRL_IDX = reg_idx(CTRL_OFS);
  localparam logic [2:0] STAT_IDX = reg_idx(STAT_OFS);
  localparam logic [2:0] INFO_IDX = reg_idx(INFO_OFS);
  localparam logic [2:0] DATA_IDX = reg_idx(DATA_OFS);

  rsa_state_e  state, state_nxt;
  logic        busy;
  logic        ap_wr, ap_word;
  logic [2:0]  ap_idx;
  logic        done, irq_en, err;
  logic [PW-1:0] in_cnt, out_ptr;
  logic [31:0] res_word, rd_mux;
  logic [31:0] unused_x_word;
  logic        unused_addr;

  logic acc, rd_acc, rd_is_word;
  logic wr_ctrl, wr_data, data_wr_ok, data_wr_err;
  logic data_rd_ok, data_rd_err;
  logic done_evt, done_err, ctrl_clr, last_word;

  assign acc        = bus.HSEL & bus.HREADY & trans_valid(bus.HTRANS);
  assign rd_acc     = acc & ~bus.HWRITE;
  assign rd_is_word = (bus.HSIZE == HSIZE_WORD);

  assign wr_ctrl     = ap_wr & (ap_idx == CTRL_IDX);
  assign wr_data     = ap_wr & (ap_idx == DATA_IDX);
  assign data_wr_ok  = wr_data & ap_word & ~busy;
  assign data_wr_err = wr_data & (~ap_word | busy);
  assign data_rd_ok  = rd_acc & (bus.HADDR[4:2] == DATA_IDX) & rd_is_word;
  assign data_rd_err = rd_acc & (bus.HADDR[4:2] == DATA_IDX) & ~rd_is_word;
  assign last_word   = data_wr_ok & (in_cnt == PW'(NWORDS - 1));

  assign done_evt = rsa_done & busy;
  assign done_err = rsa_done & ~busy;
  // A clear is honoured while busy only when it coincides with completion.
  assign ctrl_clr = wr_ctrl & bus.HWDATA[0] & (~busy | done_evt);

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = HRESP_OKAY;
  assign IRQ           = done & irq_en;
  assign dbg_state     = state;
  assign unused_addr   = ^{bus.HADDR[31:5], bus.HADDR[1:0]};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ap_wr   <= 1'b0;
      ap_idx  <= '0;
      ap_word <= 1'b0;
    end else if (bus.HREADY) begin
      ap_wr   <= acc & bus.HWRITE;
      ap_idx  <= bus.HADDR[4:2];
      ap_word <= rd_is_word;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (last_word) state_nxt = ST_START;
      ST_START: state_nxt = done_evt ? ST_IDLE : ST_BUSY;
      ST_BUSY:  if (done_evt) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b1;
    rsa_start = 1'b0;
    case (state)
      ST_IDLE:  busy = 1'b0;
      ST_START: rsa_start = 1'b1;
      default:  busy = 1'b1;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      done   <= 1'b0;
      irq_en <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= bus.HWDATA[1];
      if (done_evt)      done <= 1'b1;
      else if (ctrl_clr) done <= 1'b0;
      if (data_wr_err | data_rd_err | done_err) err <= 1'b1;
      else if (ctrl_clr)                        err <= 1'b0;
    end
  end

  rsa2048_word_buf #(.NW(NWORDS)) u_in_buf (
    .clk        (HCLK),
    .rst        (HRESET),
    .shift_en   (data_wr_ok),
    .shift_word (bus.HWDATA),
    .load_en    (1'b0),
    .load_data  ({XW{1'b0}}),
    .ptr_clr    (ctrl_clr),
    .ptr_inc    (data_wr_ok),
    .data       (rsa_x),
    .ptr        (in_cnt),
    .rd_word    (unused_x_word)
  );

  rsa2048_word_buf #(.NW(NWORDS)) u_res_buf (
    .clk        (HCLK),
    .rst        (HRESET),
    .shift_en   (1'b0),
    .shift_word (32'h0),
    .load_en    (done_evt),
    .load_data  (rsa_y),
    .ptr_clr    (done_evt | ctrl_clr),
    .ptr_inc    (data_rd_ok),
    .data       (),
    .ptr        (out_ptr),
    .rd_word    (res_word)
  );

  // Reads see register state at the address phase; the result is held for the data phase.
  always_comb begin
    rd_mux = 32'h0;
    case (bus.HADDR[4:2])
      CTRL_IDX: rd_mux = {30'b0, irq_en, 1'b0};
      STAT_IDX: rd_mux = {31'b0, done};
      INFO_IDX: rd_mux = {err, busy, 14'b0, 2'b00, out_ptr, 2'b00, in_cnt};
      DATA_IDX: rd_mux = rd_is_word ? res_word : 32'h0;
      default:  rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      bus.HRDATA <= 32'h0;
    end else if (rd_acc) begin
      bus.HRDATA <= rd_mux;
    end
  end

endmodule

// File: tb/tb_rsa2048_ahb_regs.sv
// Directed bench for rsa2048_ahb_regs: bus driver tasks push expected read data,
// a monitor pops and compares it in each read data phase.
module tb_rsa2048_ahb_regs;
  import rsa2048_ahb_pkg::*;

  logic          HCLK;
  logic          HRESET;
  logic          IRQ;
  logic [XW-1:0] rsa_x;
  logic          rsa_start;
  logic          rsa_done;
  logic [XW-1:0] rsa_y;
  rsa_state_e    dbg_state;

  rsa2048_ahb_regs_if bus ();

  rsa2048_ahb_regs dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .bus       (bus),
    .IRQ       (IRQ),
    .rsa_x     (rsa_x),
    .rsa_start (rsa_start),
    .rsa_done  (rsa_done),
    .rsa_y     (rsa_y),
    .dbg_state (dbg_state)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  int            start_cnt = 0;
  logic [31:0]   exp_q[$];
  string         name_q[$];
  logic          rd_dph = 1'b0;
  logic [XW-1:0] x_save;

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = HSIZE_WORD;
  endtask

  task automatic addr_phase(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                            input logic [1:0] trans);
    bus.HSEL   = 1'b1;
    bus.HADDR  = addr;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size);
    addr_phase(addr, 1'b1, size, HTRANS_NONSEQ);
    @(posedge HCLK); #1;
    bus_idle();
    bus.HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    addr_phase(addr, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    @(posedge HCLK); #1;
    bus_idle();
    @(posedge HCLK); #1;
  endtask

  // Pipelined DATA writes: word i's data phase overlaps word i+1's address phase.
  task automatic data_burst(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      addr_phase(DATA_OFS, 1'b1, HSIZE_WORD, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
      @(posedge HCLK); #1;
      bus.HWDATA = base + 32'(i);
    end
    bus_idle();
    @(posedge HCLK); #1;
  endtask

  task automatic read_burst(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(base + 32'(i % NWORDS));
      name_q.push_back("data_rd");
      addr_phase(DATA_OFS, 1'b0, HSIZE_WORD, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
      @(posedge HCLK); #1;
    end
    bus_idle();
    @(posedge HCLK); #1;
  endtask

  task automatic set_y(input logic [31:0] base);
    for (int i = 0; i < NWORDS; i++) rsa_y[32*i +: 32] = base + 32'(i);
  endtask

  task automatic core_done(input logic [31:0] base);
    set_y(base);
    rsa_done = 1'b1;
    @(posedge HCLK); #1;
    rsa_done = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(posedge HCLK);
      rd_dph = bus.HSEL & bus.HREADY & bus.HTRANS[1] & ~bus.HWRITE;
      @(negedge HCLK);
      if (rsa_start === 1'b1) start_cnt++;
      if (rd_dph) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_unexpected: got 0x%08h with no read expected", bus.HRDATA);
        end else begin
          check(name_q.pop_front(), bus.HRDATA, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // stimulus
  initial begin
    HRESET     = 1'b1;
    rsa_done   = 1'b0;
    rsa_y      = '0;
    bus.HREADY = 1'b1;
    bus.HWDATA = 32'h0;
    bus_idle();
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    check("rst_hrdata", bus.HRDATA, 32'h0);
    check("rst_irq", {31'b0, IRQ}, 32'h0);
    check("rst_start", {31'b0, rsa_start}, 32'h0);
    check("hresp_okay", {30'b0, bus.HRESP}, 32'h0);
    ahb_read(STAT_OFS, 32'h0, "rst_status");
    ahb_read(INFO_OFS, 32'h0, "rst_info");
    ahb_read(CTRL_OFS, 32'h0, "rst_ctrl");

    ahb_write(CTRL_OFS, 32'hFFFF_FFFF, HSIZE_WORD);
    ahb_read(CTRL_OFS, 32'h2, "ctrl_irq_en");

    data_burst(NWORDS, 32'h1);
    check("start_pulse", {31'b0, rsa_start}, 32'h1);
    @(posedge HCLK); #1;
    check("start_low", {31'b0, rsa_start}, 32'h0);
    check("start_cnt_1", 32'(start_cnt), 32'd1);
    check("rsa_x_w0", rsa_x[31:0], 32'h1);
    check("rsa_x_w1", rsa_x[63:32], 32'h2);
    check("rsa_x_w63", rsa_x[2047:2016], 32'h40);
    ahb_read(INFO_OFS, 32'h4000_0000, "info_busy");
    ahb_read(STAT_OFS, 32'h0, "status_busy");

    x_save = rsa_x;
    ahb_write(DATA_OFS, 32'hDEAD_BEEF, HSIZE_WORD);
    ahb_read(INFO_OFS, 32'hC000_0000, "info_err_busy_wr");
    check("rsa_x_hold_busy", {31'b0, rsa_x == x_save}, 32'h1);
    check("start_cnt_busy", 32'(start_cnt), 32'd1);

    core_done(32'hA000_0000);
    ahb_read(STAT_OFS, 32'h1, "status_done");
    check("irq_done", {31'b0, IRQ}, 32'h1);
    ahb_read(INFO_OFS, 32'h8000_0000, "info_after_done");
    read_burst(NWORDS + 1, 32'hA000_0000);
    ahb_read(INFO_OFS, 32'h8000_0100, "info_out_ptr_wrap");

    ahb_write(CTRL_OFS, 32'h3, HSIZE_WORD);
    ahb_read(INFO_OFS, 32'h0, "info_cleared");
    ahb_read(STAT_OFS, 32'h0, "status_cleared");
    check("irq_cleared", {31'b0, IRQ}, 32'h0);
    ahb_write(DATA_OFS, 32'h55, 3'b000);
    ahb_read(INFO_OFS, 32'h8000_0000, "info_err_byte_wr");
    check("rsa_x_hold_byte", {31'b0, rsa_x == x_save}, 32'h1);
    check("start_cnt_byte", 32'(start_cnt), 32'd1);

    ahb_write(CTRL_OFS, 32'h3, HSIZE_WORD);
    data_burst(30, 32'h100);
    ahb_read(INFO_OFS, 32'h0000_001E, "info_in_cnt_30");
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    check("rsa_x_reset", {31'b0, rsa_x == '0}, 32'h1);
    ahb_read(INFO_OFS, 32'h0, "info_after_reset");

    data_burst(NWORDS, 32'h200);
    check("start_pulse_2", {31'b0, rsa_start}, 32'h1);
    @(posedge HCLK); #1;
    check("start_cnt_2", 32'(start_cnt), 32'd2);
    check("rsa_x2_w0", rsa_x[31:0], 32'h200);
    check("rsa_x2_w63", rsa_x[2047:2016], 32'h23F);

    ahb_write(DATA_OFS, 32'h1234_5678, HSIZE_WORD);
    ahb_read(INFO_OFS, 32'hC000_0000, "info_err_before_race");

    // CTRL clear data phase coincides with rsa_done
    addr_phase(CTRL_OFS, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    @(posedge HCLK); #1;
    bus_idle();
    bus.HWDATA = 32'h1;
    set_y(32'hB000_0000);
    rsa_done = 1'b1;
    @(posedge HCLK); #1;
    rsa_done = 1'b0;
    ahb_read(INFO_OFS, 32'h0, "info_race");
    ahb_read(STAT_OFS, 32'h1, "status_race");
    check("irq_race_disabled", {31'b0, IRQ}, 32'h0);
    ahb_read(DATA_OFS, 32'hB000_0000, "data_race_w0");

    core_done(32'hC000_0000);
    ahb_read(INFO_OFS, 32'h8000_0100, "info_err_stray_done");
    ahb_read(STAT_OFS, 32'h1, "status_stray_done");
    ahb_read(DATA_OFS, 32'hB000_0001, "data_stray_w1");

    repeat (4) @(posedge HCLK);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rsa2048_ahb_regs.md
# rsa2048_ahb_regs

AHB-Lite slave register front end for the RSA2048 modular-exponentiation core. It accepts the 2048-bit operand x from the bus master as 64 sequential 32-bit words and starts the core automatically after the 64th word. It latches the core result and returns it as 64 sequential word reads. The block sits between the system AHB fabric and the core's parallel operand/result ports.

## Interface
- `NWORDS`, 64, number of 32-bit words per 2048-bit operand/result.
- `HCLK` in 1: single clock.
- `HRESET` in 1: synchronous, active-high reset.
- `HSEL` in 1: slave select.
- `HADDR` in 32: only [4:2] decoded.
- `HTRANS` in 2: NONSEQ/SEQ = valid transfer.
- `HWRITE` in 1: 1 = write.
- `HSIZE` in 3: must be 3'b010 (word).
- `HWDATA` in 32: write data (data phase).
- `HREADY` in 1: fabric ready.
- `HREADYOUT` out 1: tied 1 (zero wait).
- `HRESP` out 2: tied OKAY (2'b00).
- `HRDATA` out 32: read data, reset 0.
- `IRQ` out 1: `done & irq_en`, reset 0.
- `rsa_x` out 2048: operand buffer, reset 0.
- `rsa_start` out 1: one-cycle start pulse, reset 0.
- `rsa_done` in 1: one-cycle completion pulse from the core.
- `rsa_y` in 2048: result, valid when `rsa_done` = 1.

## Operation
- Transfer accepted when `HSEL & HREADY & HTRANS[1]`. Address-phase fields are registered, and the write takes effect in the data phase. Reads are decoded in the address phase, and `HRDATA` is registered so it is valid in the data phase.
- 0x00 CTRL (W):
  - bit0 = 1 clears `done`, `in_cnt`, `out_ptr` and `err`.
  - bit1 sets `irq_en`.
  - Reads return `{30'b0, irq_en, 1'b0}`.
- 0x04 STATUS (R): `{31'b0, done}`. Reads 0 while busy, so pollers loop until nonzero.
- 0x08 INFO (R): `{err, busy, 14'b0, out_ptr[7:0], in_cnt[7:0]}`.
- 0x10 DATA, write:
  - If idle: `rsa_x <= {HWDATA, rsa_x[2047:32]}` and `in_cnt++`. After 64 writes, the first word written sits in bits [31:0].
  - On the write that brings `in_cnt` to 64: `busy <= 1`, `in_cnt <= 0`, `rsa_start` pulses.
- 0x10 DATA, read: returns `res_buf[32*out_ptr +: 32]` (LSW first), then `out_ptr <= (out_ptr+1) mod 64`.
- On `rsa_done` while busy: `res_buf <= rsa_y`, `busy <= 0`, `done <= 1`, `out_ptr <= 0`.
- Errors (each sets sticky `err`, the access is otherwise dropped, HRESP stays OKAY):
  - DATA write while busy.
  - Non-word access to DATA.
  - `rsa_done` while not busy.
- CTRL write while busy: only `irq_en` is updated. The core has no abort.
- Unmapped offsets: writes are ignored, reads return 0.
- Reset: all state 0 (busy, done, irq_en, err, counters, `rsa_x`, `res_buf`, `HRDATA`).

## Timing
- Zero wait state; back-to-back transfers are supported.
- `rsa_start` is asserted the cycle after the data phase of the 64th DATA write. `rsa_x` is stable from that cycle until `rsa_done`.
- `done`/`IRQ` are set the cycle after `rsa_done`. A STATUS read whose address phase is in or after that cycle returns 1.
- Simultaneous CTRL bit0 write and `rsa_done`: `rsa_done` wins (done = 1, `res_buf` loaded). The clear applies only to counters and `err`.
- A DATA read in the same cycle as `rsa_done` returns the old `res_buf` word. The pointer still resets to 0.
- Reset asserted mid-load or mid-compute: all state returns to 0. A later `rsa_done` from the core counts as an error and is ignored.
- `in_cnt` never exceeds 63 as a stored value. `out_ptr` wraps 63 → 0.

## Structure
- Package `rsa2048_ahb_pkg`: offsets `CTRL_OFS=0x00`, `STAT_OFS=0x04`, `INFO_OFS=0x08`, `DATA_OFS=0x10`, `NWORDS=64`, `HTRANS`/`HRESP` encodings.
- One natural sub-module: `rsa2048_word_buf`, a 2048-bit shift-in register plus word-indexed read mux with a wrap pointer. It is instantiated once for the input and once for the result, with the result instance in parallel-load mode.

## Test plan
- Reset → `HRDATA=0`, `IRQ=0`, `rsa_start=0`; STATUS reads 0; INFO reads 0.
- CTRL write 0xFFFF_FFFF, then DATA writes 0x1..0x40 → `rsa_start` pulses once, exactly one cycle after the 64th data phase. `rsa_x[31:0]=0x1` and `rsa_x[2047:2016]=0x40`. INFO busy = 1.
- Core model returns `rsa_y = {64 words 0xA000_0000+i}` → STATUS reads 1, `IRQ=1`. 64 DATA reads return 0xA000_0000..0xA000_003F in order, then the 65th read returns 0xA000_0000 (wrap).
- DATA write during busy, and a byte write to DATA → `err=1` in INFO. `rsa_x` is unchanged and no extra `rsa_start` occurs.
- CTRL bit0 write in the same cycle as `rsa_done` → done = 1, `out_ptr` = 0, `err` cleared.
- HRESET asserted after 30 data writes → `in_cnt=0`. A subsequent full 64-word load starts normally.
